register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Parametrised successor to the single-register SAP-1 load registers (A/B/OUT style): DEPTH registers of WIDTH bits behind one write port and two asynchronous read ports.
- Each write can load, increment, decrement or clear the addressed register.
- Registered zero and carry flags report the result of the most recent write.
- Sits on the W-bus side of the datapath. Port A feeds the ALU and port B feeds the output register, which replaces discrete register instances.

Parameters:
- WIDTH, 8, data width of each register and of the bus.
- DEPTH, 4, number of registers; legal range 2..16.
- ADDR_W, 2, address width; must satisfy 2^ADDR_W >= DEPTH (elaboration-time check, fatal if violated).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nClr  input  1  asynchronous active-low reset.
- nLw  input  1  active-low write strobe; sampled on rising clk.
- op  input  2  write operation: 00 load, 01 increment, 10 decrement, 11 clear.
- waddr  input  ADDR_W  register written when nLw=0.
- in  input  WIDTH  load data (used only for op=00).
- raddr_a  input  ADDR_W  read address, port A.
- out_a  output  WIDTH  contents of register raddr_a (combinational).
- raddr_b  input  ADDR_W  read address, port B.
- out_b  output  WIDTH  contents of register raddr_b (combinational).
- zf  output  1  registered zero flag of last accepted write result.
- cf  output  1  registered carry/borrow flag of last accepted write.
- aerr  output  1  registered sticky error: a write targeted waddr >= DEPTH.

Behaviour:
- Reset:
  - nClr=0 asynchronously forces all registers to 0, zf=1, cf=0, aerr=0, regardless of clk.
  - Release is synchronised by the user; the block takes no action on deassertion.
- Write (nLw=0 at rising clk, waddr < DEPTH):
  - op=00: reg[waddr] <= in; cf <= 0.
  - op=01: reg[waddr] <= reg[waddr]+1 modulo 2^WIDTH. cf <= 1 only when the old value was all ones (wrap to 0).
  - op=10: reg[waddr] <= reg[waddr]-1 modulo 2^WIDTH. cf <= 1 only when the old value was 0 (borrow, wrap to all ones).
  - op=11: reg[waddr] <= 0; cf <= 0.
  - zf <= 1 if the new register value is 0, else 0.
  - Latency: the new value is visible on out_a/out_b the cycle after the edge.
- No write (nLw=1): registers, zf and cf hold; op, waddr and in are ignored.
- Out-of-range write (nLw=0, waddr >= DEPTH):
  - No register changes; zf and cf hold.
  - aerr <= 1 and stays 1 until nClr.
- Reads:
  - out_a = reg[raddr_a] and out_b = reg[raddr_b], purely combinational.
  - raddr >= DEPTH reads as 0.
  - Both ports may address the same register.
- Same-cycle read/write of one register:
  - Reads return the pre-edge (old) value until the edge; there is no write-through bypass.
  - Increment/decrement use the pre-edge value, so back-to-back increments on consecutive cycles each add exactly 1.
- Only one write per cycle. Other registers are never disturbed by a write.
- Reset asserted mid-sequence overrides any concurrent write that cycle.

Test Plan:
- Reset: with registers preloaded, assert nClr=0 between clk edges -> all out_a/out_b read 0x00 immediately, zf=1, cf=0, aerr=0.
- Load and dual read: load r0=0x3C, r2=0xA5, then raddr_a=0, raddr_b=2 -> out_a=0x3C, out_b=0xA5, zf=0; registers r1 and r3 still 0x00.
- Increment wrap: load r1=0xFE, then two consecutive writes with op=01 -> r1 goes 0xFF (cf=0, zf=0) then 0x00 (cf=1, zf=1).
- Decrement borrow: after clear r3 (op=11, zf=1), decrement r3 -> r3=0xFF, cf=1, zf=0; a further decrement gives 0xFE, cf=0.
- Hold and no bypass: nLw=1 with op=01 for 5 cycles -> r0 unchanged at 0x3C. Load r0=0x77 while raddr_a=0 -> out_a shows 0x3C before the edge and 0x77 after.
- Out-of-range: with DEPTH=3, ADDR_W=2, write waddr=3 data 0x55 -> no register changes, aerr=1 sticky. A subsequent read of raddr=3 gives 0x00. aerr clears only on nClr.

Source files
------------

// File: rtl/register_bank.sv
// register_bank
//   DEPTH registers of WIDTH bits with one write port and two combinational
//   read ports. Each accepted write loads, increments, decrements or clears
//   the addressed register and updates registered zero/carry flags. A write
//   aimed at an address >= DEPTH changes nothing except a sticky error flag.
//
// Ports
//   clk      in   system clock, rising edge
//   nClr     in   asynchronous active-low reset
//   nLw      in   active-low write strobe
//   op       in   00 load, 01 increment, 10 decrement, 11 clear
//   waddr    in   write address
//   in       in   load data (op = 00 only)
//   raddr_a  in   read address, port A
//   out_a    out  reg[raddr_a], 0 when raddr_a >= DEPTH
//   raddr_b  in   read address, port B
//   out_b    out  reg[raddr_b], 0 when raddr_b >= DEPTH
//   zf       out  new value of the last accepted write was zero
//   cf       out  carry/borrow of the last accepted write
//   aerr     out  sticky: some write targeted waddr >= DEPTH
module register_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              nClr,
    input  logic              nLw,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  out_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  out_b,
    output logic              zf,
    output logic              cf,
    output logic              aerr
);

    generate
        if (DEPTH < 2 || DEPTH > 16 || (2 ** ADDR_W) < DEPTH) begin : g_bad_params
            $fatal(1, "register_bank: DEPTH must be 2..16 and fit in ADDR_W bits");
        end
    endgenerate

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic             aerr_q, aerr_d;

    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH-1:0] new_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic             in_range_s;

    // Read muxes: addresses with no matching register fall through to zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        cur_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_a_s = (raddr_a == ADDR_W'(i)) ? regs_q[i] : rd_a_s;
            rd_b_s = (raddr_b == ADDR_W'(i)) ? regs_q[i] : rd_b_s;
            cur_s  = (waddr   == ADDR_W'(i)) ? regs_q[i] : cur_s;
        end
    end

    // The extra top bit of each result is the carry out / borrow out.
    assign inc_s      = {1'b0, cur_s} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s      = {1'b0, cur_s} - {{WIDTH{1'b0}}, 1'b1};
    assign in_range_s = ({1'b0, waddr} < DEPTH[ADDR_W:0]);

    // Next-state: one write per cycle, computed from pre-edge register values.
    always_comb begin
        regs_d = regs_q;
        zf_d   = zf_q;
        cf_d   = cf_q;
        aerr_d = aerr_q;
        new_s  = cur_s;
        if (!nLw && in_range_s) begin
            case (op)
                OP_LOAD: begin new_s = in;                cf_d = 1'b0;         end
                OP_INC:  begin new_s = inc_s[WIDTH-1:0];  cf_d = inc_s[WIDTH]; end
                OP_DEC:  begin new_s = dec_s[WIDTH-1:0];  cf_d = dec_s[WIDTH]; end
                OP_CLR:  begin new_s = '0;                cf_d = 1'b0;         end
                default: begin new_s = cur_s;             cf_d = cf_q;         end
            endcase
            zf_d = (new_s == '0);
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = (waddr == ADDR_W'(i)) ? new_s : regs_q[i];
            end
        end else if (!nLw) begin
            aerr_d = 1'b1;
        end else begin
            aerr_d = aerr_q;
        end
    end

    // State registers; reset clears the bank and reports a zero result.
    always_ff @(posedge clk or negedge nClr) begin
        if (!nClr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            zf_q   <= 1'b1;
            cf_q   <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            zf_q   <= zf_d;
            cf_q   <= cf_d;
            aerr_q <= aerr_d;
        end
    end

    assign out_a = rd_a_s;
    assign out_b = rd_b_s;
    assign zf    = zf_q;
    assign cf    = cf_q;
    assign aerr  = aerr_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    logic       clk = 1'b0;
    logic       nClr, nLw;
    logic [1:0] op, waddr, raddr_a, raddr_b;
    logic [7:0] din;
    logic [7:0] a4, b4, a3, b3;
    logic       zf4, cf4, ae4, zf3, cf3, ae3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = DEPTH 4 instance, index 1 = DEPTH 3 instance.
    int mem [2][4];
    bit mz [2];
    bit mc [2];
    bit ma [2];
    int dep [2] = '{4, 3};

    always #5 clk = ~clk;

    register_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u4 (
        .clk(clk), .nClr(nClr), .nLw(nLw), .op(op), .waddr(waddr), .in(din),
        .raddr_a(raddr_a), .out_a(a4), .raddr_b(raddr_b), .out_b(b4),
        .zf(zf4), .cf(cf4), .aerr(ae4));

    register_bank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u3 (
        .clk(clk), .nClr(nClr), .nLw(nLw), .op(op), .waddr(waddr), .in(din),
        .raddr_a(raddr_a), .out_a(a3), .raddr_b(raddr_b), .out_b(b3),
        .zf(zf3), .cf(cf3), .aerr(ae3));

    typedef struct {
        logic       nlw;
        logic [1:0] op;
        logic [1:0] wa;
        logic [7:0] d;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ez;
        logic       ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rd(input int k, input int addr);
        return (addr < dep[k]) ? mem[k][addr] : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) mem[k][r] = 0;
            mz[k] = 1'b1; mc[k] = 1'b0; ma[k] = 1'b0;
        end
    endtask

    task automatic model_write();
        int old, nv;
        if (nLw == 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                if (int'(waddr) >= dep[k]) begin
                    ma[k] = 1'b1;
                end else begin
                    old = mem[k][waddr];
                    case (op)
                        2'd0: begin nv = int'(din);          mc[k] = 1'b0;         end
                        2'd1: begin nv = (old + 1) % 256;    mc[k] = (old == 255); end
                        2'd2: begin nv = (old + 255) % 256;  mc[k] = (old == 0);   end
                        default: begin nv = 0;               mc[k] = 1'b0;         end
                    endcase
                    mem[k][waddr] = nv;
                    mz[k] = (nv == 0);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("u4_out_a", a4, rd(0, raddr_a));
        chk("u4_out_b", b4, rd(0, raddr_b));
        chk("u4_zf", zf4, mz[0]);
        chk("u4_cf", cf4, mc[0]);
        chk("u4_aerr", ae4, ma[0]);
        chk("u3_out_a", a3, rd(1, raddr_a));
        chk("u3_out_b", b3, rd(1, raddr_b));
        chk("u3_zf", zf3, mz[1]);
        chk("u3_cf", cf3, mc[1]);
        chk("u3_aerr", ae3, ma[1]);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (nClr) model_write();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic nlw_v, input logic [1:0] op_v, input logic [1:0] wa,
                         input logic [7:0] d, input logic [1:0] ra, input logic [1:0] rb);
        nLw = nlw_v; op = op_v; waddr = wa; din = d; raddr_a = ra; raddr_b = rb;
    endtask

    vec_t tab [9];

    initial begin
        tab[0] = '{1'b0, 2'd0, 2'd0, 8'h3C, 2'd0, 2'd0, 8'h3C, 8'h3C, 1'b0, 1'b0};
        tab[1] = '{1'b0, 2'd0, 2'd2, 8'hA5, 2'd0, 2'd2, 8'h3C, 8'hA5, 1'b0, 1'b0};
        tab[2] = '{1'b1, 2'd3, 2'd0, 8'h00, 2'd1, 2'd3, 8'h00, 8'h00, 1'b0, 1'b0};
        tab[3] = '{1'b0, 2'd0, 2'd1, 8'hFE, 2'd1, 2'd0, 8'hFE, 8'h3C, 1'b0, 1'b0};
        tab[4] = '{1'b0, 2'd1, 2'd1, 8'h00, 2'd1, 2'd2, 8'hFF, 8'hA5, 1'b0, 1'b0};
        tab[5] = '{1'b0, 2'd1, 2'd1, 8'h00, 2'd1, 2'd2, 8'h00, 8'hA5, 1'b1, 1'b1};
        tab[6] = '{1'b0, 2'd3, 2'd3, 8'h9E, 2'd3, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0};
        tab[7] = '{1'b0, 2'd2, 2'd3, 8'h00, 2'd3, 2'd1, 8'hFF, 8'h00, 1'b0, 1'b1};
        tab[8] = '{1'b0, 2'd2, 2'd3, 8'h00, 2'd3, 2'd0, 8'hFE, 8'h3C, 1'b0, 1'b0};

        nClr = 1'b0;
        drive(1'b1, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
        model_reset();
        #12;
        check_all();
        chk("reset_zf", zf4, 1'b1);
        @(negedge clk);
        nClr = 1'b1;

        // Table-driven load / increment / decrement sequence.
        for (int i = 0; i < 9; i++) begin
            drive(tab[i].nlw, tab[i].op, tab[i].wa, tab[i].d, tab[i].ra, tab[i].rb);
            step();
            chk($sformatf("tab%0d_out_a", i), a4, tab[i].ea);
            chk($sformatf("tab%0d_out_b", i), b4, tab[i].eb);
            chk($sformatf("tab%0d_zf", i), zf4, tab[i].ez);
            chk($sformatf("tab%0d_cf", i), cf4, tab[i].ec);
        end
        drive(1'b1, 2'd0, 2'd0, 8'h00, 2'd1, 2'd3);
        step();
        chk("r1_untouched", a4, 8'h00);

        // Hold: increment op with strobe inactive for five cycles.
        drive(1'b1, 2'd1, 2'd0, 8'hFF, 2'd0, 2'd2);
        for (int i = 0; i < 5; i++) step();
        chk("hold_r0", a4, 8'h3C);

        // No write-through: old value before the edge, new value after.
        drive(1'b0, 2'd0, 2'd0, 8'h77, 2'd0, 2'd0);
        #1;
        chk("nobypass_before", a4, 8'h3C);
        step();
        chk("nobypass_after", a4, 8'h77);

        // Asynchronous reset between edges, then held across a write attempt.
        drive(1'b1, 2'd0, 2'd0, 8'h00, 2'd0, 2'd2);
        chk("pre_reset_aerr3", ae3, 1'b1);
        #2;
        nClr = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_out_a", a4, 8'h00);
        chk("async_rst_aerr3", ae3, 1'b0);
        drive(1'b0, 2'd0, 2'd1, 8'h99, 2'd1, 2'd0);
        step();
        chk("rst_overrides_write", a4, 8'h00);
        nClr = 1'b1;

        // Out-of-range write on the DEPTH 3 instance.
        drive(1'b0, 2'd0, 2'd0, 8'h11, 2'd0, 2'd3); step();
        drive(1'b0, 2'd0, 2'd1, 8'h22, 2'd1, 2'd3); step();
        drive(1'b0, 2'd0, 2'd2, 8'h33, 2'd2, 2'd3); step();
        chk("oor_aerr_before", ae3, 1'b0);
        drive(1'b0, 2'd0, 2'd3, 8'h55, 2'd3, 2'd2);
        step();
        chk("oor_aerr_set", ae3, 1'b1);
        chk("oor_read3", a3, 8'h00);
        chk("oor_r2_kept", b3, 8'h33);
        chk("oor_zf_hold", zf3, 1'b0);
        chk("oor_u4_aerr", ae4, 1'b0);
        drive(1'b0, 2'd3, 2'd0, 8'h00, 2'd0, 2'd1); step();
        drive(1'b1, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1); step();
        chk("oor_aerr_sticky", ae3, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            // Bias some loads toward the wrap boundaries.
            if (i % 17 == 0) din = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
        end

        #2;
        nClr = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("final_aerr_cleared", ae3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
